// File: rtl/bp_pkg.sv
// Shared types for the branch target predictor: 2-bit saturating counter
// encoding and its named states.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'd0;
    localparam ctr_t WNT = 2'd1;
    localparam ctr_t WT  = 2'd2;
    localparam ctr_t ST  = 2'd3;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic of a 2-bit saturating direction counter:
// count up on taken, down on not-taken, holding at ST and SNT.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t i_ctr,
    input  logic i_inc,
    output ctr_t o_ctr
);

    always_comb begin
        // NOTE: default assignment first so no path leaves o_ctr unassigned (no latch).
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != ST) o_ctr = i_ctr + 2'd1;
        end else begin
            if (i_ctr != SNT) o_ctr = i_ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters, execute-stage resolution and registered redirect.
// Define BTB_JALR_PREDICT_EN to let JALR outcomes train and allocate BTB entries.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] F_PC,
    output logic            Pred_Taken,
    output logic [XLEN-1:0] Pred_PC,
    input  logic            E_Valid,
    input  logic            Branch,
    input  logic            JAL,
    input  logic            JALR,
    input  logic [XLEN-1:0] E_PC,
    input  logic [XLEN-1:0] Imm,
    input  logic [XLEN-1:0] Res,
    input  logic            E_PredTaken,
    input  logic [XLEN-1:0] E_PredPC,
    output logic [XLEN-1:0] PC4,
    output logic            Redirect,
    output logic [XLEN-1:0] Redirect_PC,
    output logic [31:0]     Mispredict_Cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        ctr_t             ctr;
    } btb_entry_t;

    btb_entry_t r_btb [ENTRIES];

    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_mp_cnt;

    // Fetch-side lookup reads the array as it stood before this edge's update.
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    btb_entry_t       w_f_ent;
    logic             w_f_hit;

    assign w_f_idx    = F_PC[IDX_W+1:2];
    assign w_f_tag    = F_PC[XLEN-1:IDX_W+2];
    assign w_f_ent    = r_btb[w_f_idx];
    assign w_f_hit    = w_f_ent.valid && (w_f_ent.tag == w_f_tag);
    assign Pred_Taken = w_f_hit && w_f_ent.ctr[1];
    assign Pred_PC    = Pred_Taken ? w_f_ent.target : F_PC + XLEN'(4);

    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next_pc;
    logic            w_mispredict;
    logic            w_class_upd;
    logic            w_update;

    assign PC4       = E_PC + XLEN'(4);
    assign w_taken   = (Branch && Res[0]) || JAL || JALR;
    assign w_target  = JALR ? {Res[XLEN-1:1], 1'b0} : E_PC + Imm;
    assign w_next_pc = w_taken ? w_target : PC4;

    assign w_mispredict = E_Valid &&
                          ((E_PredTaken != w_taken) || (w_taken && (E_PredPC != w_target)));

`ifdef BTB_JALR_PREDICT_EN
    assign w_class_upd = JALR || JAL || Branch;
`else
    // JALR outranks the other classes, so a JALR never trains the table here.
    assign w_class_upd = !JALR && (JAL || Branch);
`endif
    assign w_update = E_Valid && w_class_upd;

    logic [IDX_W-1:0] w_e_idx;
    logic [TAG_W-1:0] w_e_tag;
    btb_entry_t       w_e_ent;
    logic             w_e_hit;
    ctr_t             w_ctr_next;

    assign w_e_idx = E_PC[IDX_W+1:2];
    assign w_e_tag = E_PC[XLEN-1:IDX_W+2];
    assign w_e_ent = r_btb[w_e_idx];
    assign w_e_hit = w_e_ent.valid && (w_e_ent.tag == w_e_tag);

    bp_sat_counter u_sat_counter (
        .i_ctr (w_e_ent.ctr),
        .i_inc (w_taken),
        .o_ctr (w_ctr_next)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only valid and counter are reset; tag/target are don't-care while invalid.
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid <= 1'b0;
                r_btb[i].ctr   <= WNT;
            end
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_mp_cnt      <= '0;
        end else begin
            r_redirect    <= w_mispredict;
            r_redirect_pc <= w_next_pc;
            if (w_mispredict && (r_mp_cnt != 32'hFFFF_FFFF)) begin
                r_mp_cnt <= r_mp_cnt + 32'd1;
            end
            if (w_update) begin
                if (w_e_hit) begin
                    r_btb[w_e_idx].ctr <= w_ctr_next;
                    if (w_taken) r_btb[w_e_idx].target <= w_target;
                end else if (w_taken) begin
                    r_btb[w_e_idx].valid  <= 1'b1;
                    r_btb[w_e_idx].tag    <= w_e_tag;
                    r_btb[w_e_idx].target <= w_target;
                    r_btb[w_e_idx].ctr    <= WT;
                end
            end
        end
    end

    assign Redirect       = r_redirect;
    assign Redirect_PC    = r_redirect_pc;
    assign Mispredict_Cnt = r_mp_cnt;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized scoreboard bench for branch_target_predictor against a PC-keyed table model.
// Honours BTB_JALR_PREDICT_EN the same way the design does.
module tb_branch_target_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;

`ifdef BTB_JALR_PREDICT_EN
    localparam bit JALR_EN = 1'b1;
`else
    localparam bit JALR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] F_PC = '0;
    logic        Pred_Taken;
    logic [31:0] Pred_PC;
    logic        E_Valid = 1'b0, Branch = 1'b0, JAL = 1'b0, JALR = 1'b0;
    logic [31:0] E_PC = '0, Imm = '0, Res = '0;
    logic        E_PredTaken = 1'b0;
    logic [31:0] E_PredPC = '0;
    logic [31:0] PC4;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic [31:0] Mispredict_Cnt;

    always #5 clk = ~clk;

    branch_target_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
        .clk            (clk),
        .rst            (rst),
        .F_PC           (F_PC),
        .Pred_Taken     (Pred_Taken),
        .Pred_PC        (Pred_PC),
        .E_Valid        (E_Valid),
        .Branch         (Branch),
        .JAL            (JAL),
        .JALR           (JALR),
        .E_PC           (E_PC),
        .Imm            (Imm),
        .Res            (Res),
        .E_PredTaken    (E_PredTaken),
        .E_PredPC       (E_PredPC),
        .PC4            (PC4),
        .Redirect       (Redirect),
        .Redirect_PC    (Redirect_PC),
        .Mispredict_Cnt (Mispredict_Cnt)
    );

    typedef struct {
        bit          rst;
        logic [31:0] f_pc;
        bit          ev, br, jal, jalr;
        logic [31:0] epc, imm, res;
        bit          pt;
        logic [31:0] ppc;
    } op_t;

    typedef struct {
        bit          redir;
        bit          chk_pc;
        logic [31:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: each slot remembers which word address owns it, its target and a 0..3 confidence.
    bit          m_valid [ENTRIES];
    logic [29:0] m_word  [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_cnt = '0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit t, output logic [31:0] npc);
        int s = slot_of(pc);
        t   = m_valid[s] && (m_word[s] == pc[31:2]) && (m_ctr[s] >= 2);
        npc = t ? m_tgt[s] : pc + 32'd4;
    endfunction

    function automatic op_t nop(input logic [31:0] fpc);
        op_t o;
        o.rst = 1'b0; o.f_pc = fpc; o.ev = 1'b0; o.br = 1'b0; o.jal = 1'b0; o.jalr = 1'b0;
        o.epc = '0; o.imm = '0; o.res = '0; o.pt = 1'b0; o.ppc = '0;
        return o;
    endfunction

    function automatic op_t ex(input bit br, input bit jal, input bit jalr, input logic [31:0] epc,
                               input logic [31:0] imm, input logic [31:0] res, input bit pt,
                               input logic [31:0] ppc, input logic [31:0] fpc);
        op_t o = nop(fpc);
        o.ev = 1'b1; o.br = br; o.jal = jal; o.jalr = jalr;
        o.epc = epc; o.imm = imm; o.res = res; o.pt = pt; o.ppc = ppc;
        return o;
    endfunction

    // One fetch+execute cycle: drive, check lookup, queue the redirect expectation, train the model.
    task automatic step(input op_t op);
        bit          pt, taken, mp, upd;
        logic [31:0] ppc, target, nxt;
        exp_t        e;
        int          s;
        @(negedge clk);
        rst = op.rst; F_PC = op.f_pc; E_Valid = op.ev; Branch = op.br; JAL = op.jal; JALR = op.jalr;
        E_PC = op.epc; Imm = op.imm; Res = op.res; E_PredTaken = op.pt; E_PredPC = op.ppc;
        #1;
        model_lookup(op.f_pc, pt, ppc);
        check("pred_taken", {31'd0, Pred_Taken}, {31'd0, pt});
        check("pred_pc", Pred_PC, ppc);
        check("pc4", PC4, op.epc + 32'd4);

        taken  = (op.br && op.res[0]) || op.jal || op.jalr;
        target = op.jalr ? (op.res & 32'hFFFF_FFFE) : op.epc + op.imm;
        nxt    = taken ? target : op.epc + 32'd4;
        mp     = op.ev && ((op.pt != taken) || (taken && (op.ppc != target)));
        upd    = op.ev && (op.jalr ? JALR_EN : (op.jal || op.br));

        if (op.rst) begin
            model_reset();
            e.redir = 1'b0; e.chk_pc = 1'b1; e.pc = '0; e.cnt = '0;
        end else begin
            if (mp && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
            e.redir = mp; e.chk_pc = mp; e.pc = nxt; e.cnt = m_cnt;
            if (upd) begin
                s = slot_of(op.epc);
                if (m_valid[s] && (m_word[s] == op.epc[31:2])) begin
                    if (taken) begin
                        m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
                        m_tgt[s] = target;
                    end else begin
                        m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                    end
                end else if (taken) begin
                    m_valid[s] = 1'b1;
                    m_word[s]  = op.epc[31:2];
                    m_tgt[s]   = target;
                    m_ctr[s]   = 2;
                end
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: every registered output cycle is compared against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("redirect", {31'd0, Redirect}, {31'd0, e.redir});
                if (e.chk_pc) check("redirect_pc", Redirect_PC, e.pc);
                check("mispredict_cnt", Mispredict_Cnt, e.cnt);
            end
        end
    end

    logic [31:0] pcs  [8] = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h200, 32'h240, 32'h3c0, 32'h1000};
    logic [31:0] imms [4] = '{32'h40, 32'hFFFF_FFE0, 32'h80, 32'h1000};

    initial begin
        op_t         op;
        op_t         r;
        bit          pt;
        logic [31:0] ppc;
        model_reset();

        op = nop(32'h100); op.rst = 1'b1;
        step(op);
        step(op);

        step(nop(32'h100));
        check("reset_lookup_taken", {31'd0, Pred_Taken}, 32'd0);
        check("reset_lookup_pc", Pred_PC, 32'h104);

        step(ex(1, 0, 0, 32'h100, 32'h40, 32'h1, 0, 32'h0, 32'h100));
        step(nop(32'h100));
        check("alloc_taken", {31'd0, Pred_Taken}, 32'd1);
        check("alloc_pc", Pred_PC, 32'h140);

        step(ex(1, 0, 0, 32'h100, 32'h40, 32'h0, 1, 32'h140, 32'h100));
        step(ex(1, 0, 0, 32'h100, 32'h40, 32'h0, 0, 32'h0, 32'h100));
        step(nop(32'h100));
        check("decay_taken", {31'd0, Pred_Taken}, 32'd0);

        step(ex(1, 0, 0, 32'h100, 32'h40, 32'h1, 0, 32'h0, 32'h100));
        step(ex(1, 0, 0, 32'h140, 32'h40, 32'h1, 0, 32'h0, 32'h100));
        step(nop(32'h100));
        check("evicted_taken", {31'd0, Pred_Taken}, 32'd0);
        step(nop(32'h140));
        check("evictor_pc", Pred_PC, 32'h180);

        step(ex(0, 0, 1, 32'h300, 32'h0, 32'h2001, 0, 32'h0, 32'h300));
        step(nop(32'h300));
        check("jalr_alloc", {31'd0, Pred_Taken}, {31'd0, JALR_EN});

        op = ex(1, 0, 0, 32'h200, 32'h40, 32'h1, 0, 32'h0, 32'h140); op.rst = 1'b1;
        step(op);
        step(nop(32'h140));
        check("post_reset_miss", {31'd0, Pred_Taken}, 32'd0);
        step(nop(32'h300));

        for (int n = 0; n < 400; n++) begin
            int k;
            r   = nop(pcs[$urandom_range(0, 7)]);
            r.rst = ($urandom_range(0, 49) == 0);
            r.ev  = ($urandom_range(0, 7) != 0);
            k     = $urandom_range(0, 9);
            r.br   = (k <= 4);
            r.jal  = (k == 5) || (k == 6);
            r.jalr = (k == 7) || (k == 8);
            if ($urandom_range(0, 7) == 0) begin
                r.br = $urandom_range(0, 1); r.jal = $urandom_range(0, 1); r.jalr = $urandom_range(0, 1);
            end
            r.epc = pcs[$urandom_range(0, 7)];
            r.imm = imms[$urandom_range(0, 3)];
            r.res = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                model_lookup(r.epc, pt, ppc);
                r.pt = pt; r.ppc = ppc;
            end else begin
                r.pt = $urandom_range(0, 1);
                r.ppc = pcs[$urandom_range(0, 7)];
            end
            step(r);
        end

        step(nop(32'h0));
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter ENTRIES, default 16, BTB depth; power of two, 2..256.
REQ-003 SHALL use derived IDX_W = log2(ENTRIES) and TAG_W = XLEN-2-IDX_W.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports (name  dir  width  meaning):
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 F_PC  in  XLEN  fetch PC to look up
 Pred_Taken  out  1  fetch prediction, combinational
 Pred_PC  out  XLEN  predicted next PC, combinational
 E_Valid  in  1  execute-stage instruction valid
 Branch / JAL / JALR  in  1 each  resolved instruction class
 E_PC  in  XLEN  execute-stage PC
 Imm  in  XLEN  immediate
 Res  in  XLEN  ALU result; Res[0] is the branch condition
 E_PredTaken  in  1  prediction carried down the pipe
 E_PredPC  in  XLEN  predicted PC carried down the pipe
 PC4  out  XLEN  E_PC+4 link value, combinational
 Redirect  out  1  registered flush request
 Redirect_PC  out  XLEN  registered correct next PC
 Mispredict_Cnt  out  32  saturating mispredict counter

Function
REQ-006 Entry SHALL hold: valid, tag = PC[XLEN-1:IDX_W+2], target (XLEN), 2-bit saturating counter. Index = PC[IDX_W+1:2].
REQ-007 Lookup SHALL be combinational: hit = valid and tag match at F_PC index. Pred_Taken = hit and counter[1]. Pred_PC = target if Pred_Taken, else F_PC+4.
REQ-008 Actual outcome SHALL be: taken = (Branch and Res[0]) or JAL or JALR.
REQ-009 Actual target SHALL be {Res[XLEN-1:1],1'b0} for JALR, else E_PC+Imm.
REQ-010 Actual next PC SHALL be the target if taken, else E_PC+4. All adds SHALL be modulo 2^XLEN.
REQ-011 Mispredict SHALL be E_Valid and (E_PredTaken != taken, or taken and E_PredPC != target).
REQ-012 Redirect and Redirect_PC SHALL register the mispredict flag and the actual next PC; latency one cycle. Redirect SHALL be a one-cycle pulse per mispredict.
REQ-013 Update SHALL occur at the clock edge when E_Valid and (Branch or JAL or JALR-if-enabled).
 - Hit: counter +1 if taken (saturate at 3), -1 if not taken (saturate at 0). Target is written only if taken.
 - Miss and taken: allocate the entry (valid=1, tag, target, counter=2'b10), overwriting any occupant.
 - Miss and not taken: no write.
REQ-014 A lookup and an update to the same index in the same cycle SHALL return the pre-update contents (no bypass).
REQ-015 Mispredict_Cnt SHALL increment on each mispredict and saturate at 32'hFFFFFFFF.
REQ-016 If more than one of Branch, JAL and JALR is high, priority SHALL be JALR > JAL > Branch.

Reset
REQ-017 While rst=1: all valid bits 0, all counters 2'b01, Redirect 0, Redirect_PC 0, Mispredict_Cnt 0. Updates SHALL be suppressed in the reset cycle.
REQ-018 Reset asserted mid-operation SHALL drop any pending redirect. Outputs SHALL be clean on the cycle after rst falls.

Configuration
REQ-019 With macro BTB_JALR_PREDICT_EN defined, JALR outcomes SHALL update and allocate BTB entries.
REQ-020 Without BTB_JALR_PREDICT_EN, JALR SHALL never update or allocate entries. JALR misprediction detection and redirect SHALL still operate.

Structure
REQ-021 Package bp_pkg SHALL hold the 2-bit counter typedef, the counter constants (SNT=0, WNT=1, WT=2, ST=3) and the btb_entry_t struct parameterised by widths via typedef in the module.
REQ-022 One sub-module, bp_sat_counter (2-bit saturating next-state logic), SHALL be instantiated per update path. Resolution logic SHALL stay in the top module.

Verification
REQ-023 After reset, F_PC=0x100 -> Pred_Taken=0, Pred_PC=0x104.
REQ-024 Taken branch at E_PC=0x100, Imm=0x40, E_PredTaken=0 -> next cycle Redirect=1, Redirect_PC=0x140, Mispredict_Cnt=1. Subsequent F_PC=0x100 -> Pred_Taken=1, Pred_PC=0x140.
REQ-025 Two not-taken resolutions of the branch at 0x100 -> counter 2->1->0, Pred_Taken=0. A correctly predicted resolution -> Redirect=0.
REQ-026 With ENTRIES=16, taken branches at 0x100 and 0x140 (same index) -> 0x140 evicts 0x100, and lookup of 0x100 misses.
REQ-027 JALR with Res=0x2001 -> Redirect_PC=0x2000. The entry is allocated only if BTB_JALR_PREDICT_EN is defined.
REQ-028 rst asserted in the cycle a mispredict resolves -> Redirect stays 0, and all lookups miss afterward.
